// File: rtl/ofdm_ifft_ctrl.sv
// ofdm_ifft_ctrl: streams frames into an FFT core and reorders its results, optionally adding a cyclic prefix.
// Define OFDM_CP_INSERT_EN to prepend the last CP_LEN samples of every output symbol.
module ofdm_ifft_ctrl #(
  parameter int DW = 16,
  parameter int LOG2N = 5,
  parameter int CP_LEN = 8,
  parameter logic [2*((LOG2N+1)/2)-1:0] SCALE = 6'b101010
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 in_i,
  input  logic [DW-1:0]                 in_q,
  input  logic                          core_rfd,
  output logic                          core_start,
  output logic                          core_fwd_inv,
  output logic                          core_fwd_inv_we,
  output logic                          core_scale_sch_we,
  output logic [2*((LOG2N+1)/2)-1:0]    core_scale_sch,
  output logic [DW-1:0]                 core_xn_re,
  output logic [DW-1:0]                 core_xn_im,
  output logic [LOG2N-1:0]              core_xn_index,
  input  logic                          core_dv,
  input  logic [DW-1:0]                 core_xk_re,
  input  logic [DW-1:0]                 core_xk_im,
  input  logic [LOG2N-1:0]              core_xk_index,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DW-1:0]                 out_i,
  output logic [DW-1:0]                 out_q,
  output logic                          out_first,
  output logic                          out_last,
  output logic                          ovf
);
  localparam int N = 1 << LOG2N;
`ifdef OFDM_CP_INSERT_EN
  localparam int TOT = N + CP_LEN;
`else
  localparam int TOT = N;
`endif
  typedef enum logic {COLLECT, EMIT} state_t;
  state_t state;
  logic [LOG2N-1:0] in_cnt, wr_cnt, first_addr, next_addr;
  logic [LOG2N:0] beat;
  logic [2*DW-1:0] mem [N];
  logic [2*DW-1:0] first_dat;
  logic acc, wr, adv, fin;
  function automatic logic [LOG2N-1:0] addr_of(input logic [LOG2N:0] b);
`ifdef OFDM_CP_INSERT_EN
    return int'(b) < CP_LEN ? LOG2N'(N - CP_LEN + int'(b)) : LOG2N'(int'(b) - CP_LEN);
`else
    return LOG2N'(b);
`endif
  endfunction
  assign in_ready = core_rfd;
  assign acc = in_valid & core_rfd;
  assign wr = core_dv && state == COLLECT;
  assign adv = out_valid & out_ready;
  assign fin = adv && beat == (LOG2N+1)'(TOT - 1);
  assign first_addr = addr_of('0);
  assign next_addr = addr_of(beat + 1'b1);
  // the last result may land on the very first address to emit, so bypass the buffer
  assign first_dat = core_xk_index == first_addr ? {core_xk_re, core_xk_im} : mem[first_addr];
  always_ff @(posedge clk)
    if (wr) mem[core_xk_index] <= {core_xk_re, core_xk_im};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt <= '0;
      core_start <= 1'b0;
      core_fwd_inv <= 1'b0;
      core_fwd_inv_we <= 1'b0;
      core_scale_sch_we <= 1'b0;
      core_scale_sch <= '0;
      core_xn_re <= '0;
      core_xn_im <= '0;
      core_xn_index <= '0;
      state <= COLLECT;
      wr_cnt <= '0;
      beat <= '0;
      out_valid <= 1'b0;
      out_i <= '0;
      out_q <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      ovf <= 1'b0;
    end else begin
      core_scale_sch <= SCALE;
      core_start <= acc && in_cnt == '0;
      core_fwd_inv_we <= acc && in_cnt == '0;
      core_scale_sch_we <= acc && in_cnt == '0;
      if (acc && in_cnt == '0) core_fwd_inv <= mode;
      if (acc) begin
        in_cnt <= in_cnt + 1'b1;
        core_xn_re <= in_i;
        core_xn_im <= in_q;
        core_xn_index <= in_cnt;
      end
      if (state == COLLECT) begin
        if (core_dv) begin
          wr_cnt <= wr_cnt + 1'b1;
          if (wr_cnt == '1) begin
            state <= EMIT;
            beat <= '0;
            out_valid <= 1'b1;
            {out_i, out_q} <= first_dat;
            out_first <= 1'b1;
            out_last <= 1'b0;
          end
        end
      end else begin
        if (core_dv) ovf <= 1'b1;
        if (fin) begin
          state <= COLLECT;
          beat <= '0;
          out_valid <= 1'b0;
          out_first <= 1'b0;
          out_last <= 1'b0;
        end else if (adv) begin
          beat <= beat + 1'b1;
          {out_i, out_q} <= mem[next_addr];
          out_first <= 1'b0;
          out_last <= beat + 1'b1 == (LOG2N+1)'(TOT - 1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ofdm_ifft_ctrl.sv
// tb_ofdm_ifft_ctrl: randomized directed bench for ofdm_ifft_ctrl with an echoing core model and a symbol-level output model.
module tb_ofdm_ifft_ctrl;
  localparam int DW = 16, LOG2N = 5, N = 32, CP = 8;
  localparam logic [5:0] SC = 6'b101010;
`ifdef OFDM_CP_INSERT_EN
  localparam int TOT = N + CP;
`else
  localparam int TOT = N;
`endif
  logic clk = 1'b0, reset, mode, in_valid, in_ready, core_rfd, core_start, core_fwd_inv;
  logic core_fwd_inv_we, core_scale_sch_we, core_dv, out_valid, out_ready, out_first, out_last, ovf;
  logic [5:0] core_scale_sch;
  logic [DW-1:0] in_i, in_q, core_xn_re, core_xn_im, core_xk_re, core_xk_im, out_i, out_q;
  logic [LOG2N-1:0] core_xn_index, core_xk_index;
  int checks = 0, errors = 0;
  logic [31:0] fr [N];
  logic [31:0] exp_q [$];

  ofdm_ifft_ctrl #(.DW(DW), .LOG2N(LOG2N), .CP_LEN(CP), .SCALE(SC)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .core_rfd(core_rfd), .core_start(core_start),
    .core_fwd_inv(core_fwd_inv), .core_fwd_inv_we(core_fwd_inv_we),
    .core_scale_sch_we(core_scale_sch_we), .core_scale_sch(core_scale_sch),
    .core_xn_re(core_xn_re), .core_xn_im(core_xn_im), .core_xn_index(core_xn_index),
    .core_dv(core_dv), .core_xk_re(core_xk_re), .core_xk_im(core_xk_im),
    .core_xk_index(core_xk_index), .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_q(out_q), .out_first(out_first), .out_last(out_last), .ovf(ovf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] brev(input logic [4:0] x);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = x[4-i];
    return r;
  endfunction

  task automatic check_xn(input int k, input logic m0);
    chk("xn_index", core_xn_index, k);
    chk("xn_re", core_xn_re, fr[k][31:16]);
    chk("xn_im", core_xn_im, fr[k][15:0]);
    chk("core_start", core_start, k == 0);
    chk("fwd_inv_we", core_fwd_inv_we, k == 0);
    chk("scale_we", core_scale_sch_we, k == 0);
    chk("fwd_inv", core_fwd_inv, m0);
  endtask

  // offers nsamp samples; mode is m0 only on sample 0 so the frame-start sampling is exercised
  task automatic feed(input logic [15:0] base, input int nsamp, input logic m0);
    for (int k = 0; k < nsamp; k++) begin
      bit done = 0;
      int tries = 0;
      in_i = base + 16'(k);
      in_q = 16'($urandom);
      fr[k] = {in_i, in_q};
      mode = k == 0 ? m0 : ~m0;
      in_valid = 1'b1;
      while (!done) begin
        core_rfd = tries > 6 || $urandom_range(0, 3) != 0;
        #1;
        chk("in_ready", in_ready, core_rfd);
        done = core_rfd;
        tries++;
        tick();
      end
      in_valid = 1'b0;
      core_rfd = 1'b0;
      check_xn(k, m0);
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  // echo core: returns each input sample at its own index, in natural or bit-reversed order
  task automatic core_resp(input bit bitrev);
    for (int j = 0; j < N; j++) begin
      logic [4:0] a;
      a = bitrev ? brev(5'(j)) : 5'(j);
      if ($urandom_range(0, 3) == 0) tick();
      core_dv = 1'b1;
      core_xk_index = a;
      core_xk_re = fr[a][31:16];
      core_xk_im = fr[a][15:0];
      tick();
      core_dv = 1'b0;
      if (j == N - 2) chk("collect_no_valid", out_valid, 1'b0);
    end
    exp_q.delete();
`ifdef OFDM_CP_INSERT_EN
    for (int j = N - CP; j < N; j++) exp_q.push_back(fr[j]);
`endif
    for (int j = 0; j < N; j++) exp_q.push_back(fr[j]);
  endtask

  task automatic drain(input int stall_at, input int dv_at, input bit feed_next);
    int b = 0, cyc = 0, stalls = 0, k = 0;
    bit dv_done = 0, in_acc;
    while (b < TOT && cyc < 2000) begin
      chk("out_valid", out_valid, 1'b1);
      chk("out_i", out_i, exp_q[b][31:16]);
      chk("out_q", out_q, exp_q[b][15:0]);
      chk("out_first", out_first, b == 0);
      chk("out_last", out_last, b == TOT - 1);
      if (b == stall_at && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
      end else out_ready = stall_at >= 0 || $urandom_range(0, 3) != 0;
      core_dv = b == dv_at && !dv_done;
      core_xk_index = '0;
      core_xk_re = 16'hdead;
      core_xk_im = 16'hbeef;
      in_acc = feed_next && k < N;
      if (in_acc) begin
        in_i = 16'(300 + k);
        in_q = 16'($urandom);
        fr[k] = {in_i, in_q};
        mode = k != 0;
      end
      in_valid = in_acc;
      core_rfd = 1'b1;
      tick();
      if (core_dv) begin
        chk("ovf_set", ovf, 1'b1);
        dv_done = 1;
      end
      core_dv = 1'b0;
      if (in_acc) begin
        check_xn(k, 1'b0);
        k++;
      end
      if (out_ready) b++;
      cyc++;
    end
    in_valid = 1'b0;
    core_rfd = 1'b0;
    out_ready = 1'b0;
    chk("drain_beats", b, TOT);
    if (stall_at >= 0) chk("stall_cycles", stalls, 5);
    chk("back_to_collect", out_valid, 1'b0);
  endtask

  task automatic chk_reset();
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_fwd_inv", core_fwd_inv, 1'b0);
    chk("rst_scale", core_scale_sch, 6'd0);
    chk("rst_xn", {core_xn_re, core_xn_im, 11'd0, core_xn_index}, 0);
    chk("rst_out", {out_valid, out_first, out_last, ovf, out_i, out_q}, 0);
  endtask

  initial begin
    reset = 1'b1;
    {mode, in_valid, core_rfd, core_dv, out_ready} = '0;
    {in_i, in_q, core_xk_re, core_xk_im, core_xk_index} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    reset = 1'b0;
    tick();
    chk("scale_sch", core_scale_sch, SC);
    chk("scale_we_idle", core_scale_sch_we, 1'b0);
    feed(16'd0, N, 1'b1);
    core_resp(1'b0);
    drain(10, -1, 1'b0);
    chk("ovf_clear", ovf, 1'b0);
    feed(16'd200, N, 1'b0);
    core_resp(1'b1);
    drain(-1, 20, 1'b1);
    core_resp(1'b0);
    drain(-1, -1, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);
    feed(16'd400, 17, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset();
    tick();
    reset = 1'b0;
    tick();
    feed(16'd500, N, 1'b0);
    core_resp(1'b1);
    drain(-1, -1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
